keypad_entry_ctrl: RTL and testbench
====================================

# keypad_entry_ctrl

Sequences keypad input for the calculator datapath. Consumes the raw key code and press flag from the keypad decoder, debounces them into single key events, and assembles a BCD operand A, an operator and a BCD operand B. On '=' it launches the arithmetic unit with a start/done handshake, then selects the result for display and supports chaining into the next operation.

## Interface
- DEBOUNCE_CYCLES, 2_000_000: cycles a press or release must be stable before it is accepted (20 ms at 100 MHz).
- DIGITS, 4: BCD digits per operand.
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_code  in  4  decoder key code: 0–9 digits, A–D operators, E '=', F clear.
- key_valid  in  1  decoder press flag; high while a key is held.
- result  in  4*DIGITS  BCD result from the arithmetic unit; valid when calc_done is high.
- calc_done  in  1  one-cycle completion pulse from the arithmetic unit.
- operand_a  out  4*DIGITS  BCD operand A.
- operand_b  out  4*DIGITS  BCD operand B.
- op  out  2  operator: 00 add (A), 01 sub (B), 10 mul (C), 11 div (D).
- calc_start  out  1  one-cycle launch pulse.
- display_sel  out  2  display source: 00 A, 01 B, 10 result.

## Operation
- Input path:
  - key_code and key_valid pass through a 2-flop synchronizer.
  - A stable counter resets whenever the synchronized {key_valid, key_code} changes.
  - Key event (key_evt, one cycle): synchronized key_valid=1, the block is armed, and the counter reaches DEBOUNCE_CYCLES-1.
  - key_evt disarms the block. It re-arms only after key_valid=0 has been stable for DEBOUNCE_CYCLES.
  - Holding a key therefore yields exactly one event.
  - A code change while held restarts the counter but does not re-arm.
- Digit entry: the digit shifts into the active operand as {operand[4*DIGITS-5:0], digit}. Each operand has a digit counter that saturates at DIGITS. Digits beyond DIGITS are ignored.
- FSM states: ENTER_A, ENTER_B, WAIT_CALC, SHOW_RESULT.
- ENTER_A (display_sel=00):
  - Digit: shifts into operand_a.
  - A–D: latch op, clear operand_b and its count, go to ENTER_B.
  - E: ignored.
- ENTER_B (display_sel=01):
  - Digit: shifts into operand_b.
  - A–D: replace op, stay in ENTER_B.
  - E with b count=0: ignored.
  - E with b count>0: pulse calc_start, go to WAIT_CALC.
- WAIT_CALC (display_sel=10): every key, including F, is ignored. calc_done goes to SHOW_RESULT.
- SHOW_RESULT (display_sel=10):
  - Digit: clear both operands, operand_a=digit, a count=1, go to ENTER_A.
  - A–D: operand_a<=result held at done, a count=DIGITS, latch op, clear B, go to ENTER_B.
  - E: ignored.
- F in ENTER_A, ENTER_B or SHOW_RESULT: operands, counts and op cleared, go to ENTER_A.
- The result is latched internally on calc_done.

## Timing
- Reset values:
  - Outputs: operand_a=0, operand_b=0, op=00, calc_start=0, display_sel=00.
  - Internal: state=ENTER_A, counts=0, armed=1, stable counter=0.
  - Reset is legal mid-entry and mid-calculation. A calc_done arriving after reset is ignored.
- Latency: key_evt occurs 2+DEBOUNCE_CYCLES cycles after key_valid rises with a constant code. Registered outputs change on the next edge.
- calc_start is high for exactly one cycle, on the edge that enters WAIT_CALC. operand_a, operand_b and op stay frozen until calc_done.
- calc_done outside WAIT_CALC: ignored.
- key_evt coinciding with calc_done in WAIT_CALC: done is taken, the key is dropped.
- calc_done the cycle after calc_start is legal.

## Structure
- Package keypad_pkg holds:
  - key code constants KEY_0..KEY_9, KEY_ADD..KEY_DIV, KEY_EQ, KEY_CLR;
  - op encodings;
  - the FSM state enum;
  - display_sel encodings.
- Sub-module key_debounce: synchronizer, stable counter, arm/release logic, one-shot key_evt and held code.
- Top: FSM, operand shift registers and counters, result latch.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, DIGITS=4.
- Keys 1,2,3 then A then 4,5 then E → operand_a=0x0123, op=00, operand_b=0x0045, one calc_start pulse, display_sel 00→01→10.
- key_valid bouncing every 2 cycles for 20 cycles, then stable on 7 → exactly one digit 7 accepted. Holding 7 for 100 cycles adds no further digits.
- Keys 9,8,7,6,5 in ENTER_A → operand_a=0x9876, fifth digit ignored. Then E → ignored, state remains ENTER_A.
- Keys A then C in ENTER_B with no digits, then E → op=10, no calc_start.
- In WAIT_CALC press F, then calc_done with result=0x0168 → F ignored, SHOW_RESULT. Then key B → operand_a=0x0168, op=01, operand_b=0, ENTER_B.
- rst_n low mid-WAIT_CALC, then calc_done → all outputs at reset values, calc_start stays 0, state ENTER_A.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, operator and display encodings
// for the calculator keypad entry controller.
package keypad_pkg;

  localparam logic [3:0] KEY_0   = 4'h0;
  localparam logic [3:0] KEY_1   = 4'h1;
  localparam logic [3:0] KEY_2   = 4'h2;
  localparam logic [3:0] KEY_3   = 4'h3;
  localparam logic [3:0] KEY_4   = 4'h4;
  localparam logic [3:0] KEY_5   = 4'h5;
  localparam logic [3:0] KEY_6   = 4'h6;
  localparam logic [3:0] KEY_7   = 4'h7;
  localparam logic [3:0] KEY_8   = 4'h8;
  localparam logic [3:0] KEY_9   = 4'h9;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ENTER_A,
    ENTER_B,
    WAIT_CALC,
    SHOW_RESULT
  } state_e;

  typedef enum logic [1:0] {
    DISP_A   = 2'b00,
    DISP_B   = 2'b01,
    DISP_RES = 2'b10
  } disp_e;

  function automatic logic is_digit(logic [3:0] k);
    return k <= KEY_9;
  endfunction

  function automatic logic is_opkey(logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  function automatic op_e key_to_op(logic [3:0] k);
    return op_e'(2'(k - KEY_ADD));
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_debounce.sv
// Synchronizes and debounces the raw keypad code/press
// flag into a single one-cycle event per key press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_key_code,
  input  logic       i_key_valid,
  output logic       o_key_evt,
  output logic [3:0] o_key_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] TOP = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]    r_s1;
  logic [4:0]    r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          w_valid;
  logic          w_stable;
  logic          w_evt;

  assign w_valid    = r_s2[4];
  assign w_stable   = (r_cnt == TOP);
  assign w_evt      = w_valid & r_armed & w_stable;
  assign o_key_evt  = w_evt;
  assign o_key_code = r_s2[3:0];

  // two-flop synchronizer on {valid, code}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {i_key_valid, i_key_code};
      r_s2 <= r_s1;
    end
  end

  // stability counter, restarts on any change, saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_s1 != r_s2) begin
      r_cnt <= '0;
    end else if (!w_stable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // one event per press; re-arm after a stable release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
    end else if (w_evt) begin
      r_armed <= 1'b0;
    end else if (!w_valid && w_stable) begin
      r_armed <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: operand/operator assembly and
// start/done handshake with the arithmetic unit.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int DIGITS          = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          key_code,
  input  logic                key_valid,
  input  logic [4*DIGITS-1:0] result,
  input  logic                calc_done,
  output logic [4*DIGITS-1:0] operand_a,
  output logic [4*DIGITS-1:0] operand_b,
  output logic [1:0]          op,
  output logic                calc_start,
  output logic [1:0]          display_sel
);

  localparam int W  = 4 * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [NW-1:0] FULL = NW'(DIGITS);

  logic         w_evt;
  logic [3:0]   w_code;
  logic         w_dig;
  logic         w_opk;
  logic         w_eq;
  logic         w_clr;

  state_e       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_res;
  logic [NW-1:0] r_na;
  logic [NW-1:0] r_nb;
  op_e          r_op;
  logic         r_start;
  disp_e        r_disp;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_key_code (key_code),
    .i_key_valid(key_valid),
    .o_key_evt  (w_evt),
    .o_key_code (w_code)
  );

  assign w_dig = is_digit(w_code);
  assign w_opk = is_opkey(w_code);
  assign w_eq  = (w_code == KEY_EQ);
  assign w_clr = (w_code == KEY_CLR);

  assign operand_a   = r_a;
  assign operand_b   = r_b;
  assign op          = r_op;
  assign calc_start  = r_start;
  assign display_sel = r_disp;

  // entry FSM with operands, counts and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_na    <= '0;
      r_nb    <= '0;
      r_op    <= OP_ADD;
      r_start <= 1'b0;
      r_disp  <= DISP_A;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        ENTER_A: begin
          if (w_evt) begin
            unique case (1'b1)
              w_dig: begin
                if (r_na < FULL) begin
                  r_a  <= {r_a[W-5:0], w_code};
                  r_na <= r_na + 1'b1;
                end
              end
              w_opk: begin
                r_op    <= key_to_op(w_code);
                r_b     <= '0;
                r_nb    <= '0;
                r_state <= ENTER_B;
                r_disp  <= DISP_B;
              end
              w_clr: begin
                r_a     <= '0;
                r_b     <= '0;
                r_na    <= '0;
                r_nb    <= '0;
                r_op    <= OP_ADD;
                r_state <= ENTER_A;
                r_disp  <= DISP_A;
              end
              default: ;
            endcase
          end
        end
        ENTER_B: begin
          if (w_evt) begin
            unique case (1'b1)
              w_dig: begin
                if (r_nb < FULL) begin
                  r_b  <= {r_b[W-5:0], w_code};
                  r_nb <= r_nb + 1'b1;
                end
              end
              w_opk: r_op <= key_to_op(w_code);
              w_eq: begin
                if (r_nb != '0) begin
                  r_start <= 1'b1;
                  r_state <= WAIT_CALC;
                  r_disp  <= DISP_RES;
                end
              end
              w_clr: begin
                r_a     <= '0;
                r_b     <= '0;
                r_na    <= '0;
                r_nb    <= '0;
                r_op    <= OP_ADD;
                r_state <= ENTER_A;
                r_disp  <= DISP_A;
              end
              default: ;
            endcase
          end
        end
        WAIT_CALC: begin
          if (calc_done) begin
            r_res   <= result;
            r_state <= SHOW_RESULT;
          end
        end
        SHOW_RESULT: begin
          if (w_evt) begin
            unique case (1'b1)
              w_dig: begin
                r_a     <= {{(W-4){1'b0}}, w_code};
                r_b     <= '0;
                r_na    <= NW'(1);
                r_nb    <= '0;
                r_state <= ENTER_A;
                r_disp  <= DISP_A;
              end
              w_opk: begin
                r_a     <= r_res;
                r_na    <= FULL;
                r_op    <= key_to_op(w_code);
                r_b     <= '0;
                r_nb    <= '0;
                r_state <= ENTER_B;
                r_disp  <= DISP_B;
              end
              w_clr: begin
                r_a     <= '0;
                r_b     <= '0;
                r_na    <= '0;
                r_nb    <= '0;
                r_op    <= OP_ADD;
                r_state <= ENTER_A;
                r_disp  <= DISP_A;
              end
              default: ;
            endcase
          end
        end
        default: r_state <= ENTER_A;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed key sequences
// checked against a calculator-level entry model.
module tb_keypad_entry_ctrl;

  localparam int DB = 4;
  localparam int DG = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] result;
  logic        calc_done;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [1:0]  op;
  logic        calc_start;
  logic [1:0]  display_sel;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DIGITS         (DG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .result     (result),
    .calc_done  (calc_done),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .op         (op),
    .calc_start (calc_start),
    .display_sel(display_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_start = 0;
  logic chk_en = 1'b0;
  logic prev_start = 1'b0;

  // model: 0 entering A, 1 entering B, 2 waiting, 3 showing result
  int          m_st;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [15:0] m_res;
  logic [1:0]  m_op;
  int          m_ca;
  int          m_cb;
  int          m_starts;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] m_disp();
    if (m_st == 0) return 2'b00;
    if (m_st == 1) return 2'b01;
    return 2'b10;
  endfunction

  task automatic model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_res = 0;
    m_op = 0; m_ca = 0; m_cb = 0;
  endtask

  task automatic model_clear();
    m_st = 0; m_a = 0; m_b = 0;
    m_op = 0; m_ca = 0; m_cb = 0;
  endtask

  task automatic model_key(logic [3:0] c);
    logic is_d;
    logic is_o;
    is_d = (c <= 4'd9);
    is_o = (c >= 4'hA) && (c <= 4'hD);
    if (m_st == 2) return;
    if (c == 4'hF) begin
      model_clear();
      return;
    end
    case (m_st)
      0: begin
        if (is_d && m_ca < DG) begin
          m_a = (m_a << 4) | 16'(c);
          m_ca++;
        end else if (is_o) begin
          m_op = 2'(c - 4'hA);
          m_b = 0; m_cb = 0; m_st = 1;
        end
      end
      1: begin
        if (is_d && m_cb < DG) begin
          m_b = (m_b << 4) | 16'(c);
          m_cb++;
        end else if (is_o) begin
          m_op = 2'(c - 4'hA);
        end else if (c == 4'hE && m_cb > 0) begin
          m_starts++;
          m_st = 2;
        end
      end
      3: begin
        if (is_d) begin
          m_a = 16'(c); m_b = 0;
          m_ca = 1; m_cb = 0; m_st = 0;
        end else if (is_o) begin
          m_a = m_res; m_ca = DG;
          m_op = 2'(c - 4'hA);
          m_b = 0; m_cb = 0; m_st = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(logic [3:0] c);
    chk_en = 1'b0;
    key_code = c;
    key_valid = 1'b1;
    model_key(c);
    tick(DB + 10);
    key_valid = 1'b0;
    tick(DB + 10);
    chk_en = 1'b1;
    tick(2);
  endtask

  task automatic done_pulse(logic [15:0] r);
    result = r;
    calc_done = 1'b1;
    if (m_st == 2) begin
      m_res = r;
      m_st = 3;
    end
    tick(1);
    calc_done = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk_en = 1'b1;
  endtask

  // per-cycle comparison against the model once outputs settle
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      cmp("operand_a", 32'(operand_a), 32'(m_a));
      cmp("operand_b", 32'(operand_b), 32'(m_b));
      cmp("op", 32'(op), 32'(m_op));
      cmp("display_sel", 32'(display_sel), 32'(m_disp()));
      cmp("calc_start_idle", 32'(calc_start), 32'd0);
    end
  end

  // count launch pulses and require them to be one cycle wide
  always @(negedge clk) begin
    if (calc_start) begin
      n_start++;
      cmp("start_width", 32'(prev_start), 32'd0);
    end
    prev_start <= calc_start;
  end

  initial begin
    rst_n = 1'b0;
    key_code = 4'h0;
    key_valid = 1'b0;
    result = 16'h0;
    calc_done = 1'b0;
    m_starts = 0;
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    cmp("rst_a", 32'(operand_a), 32'h0);
    cmp("rst_b", 32'(operand_b), 32'h0);
    cmp("rst_op", 32'(op), 32'h0);
    cmp("rst_disp", 32'(display_sel), 32'h0);
    cmp("rst_start", 32'(calc_start), 32'h0);
    chk_en = 1'b1;

    // basic 123 + 45 =
    press(4'h1); press(4'h2); press(4'h3);
    cmp("s1_disp_a", 32'(display_sel), 32'h0);
    press(4'hA);
    cmp("s1_disp_b", 32'(display_sel), 32'h1);
    press(4'h4); press(4'h5); press(4'hE);
    cmp("s1_a", 32'(operand_a), 32'h0123);
    cmp("s1_b", 32'(operand_b), 32'h0045);
    cmp("s1_op", 32'(op), 32'h0);
    cmp("s1_disp_r", 32'(display_sel), 32'h2);
    cmp("s1_starts", 32'(n_start), 32'd1);
    done_pulse(16'h0168);
    press(4'hF);
    cmp("s1_clr_a", 32'(operand_a), 32'h0);

    // bouncing press, then a long hold of 7
    chk_en = 1'b0;
    key_code = 4'h7;
    for (int i = 0; i < 10; i++) begin
      key_valid = ~key_valid;
      tick(2);
    end
    key_valid = 1'b1;
    model_key(4'h7);
    tick(100);
    key_valid = 1'b0;
    tick(DB + 10);
    chk_en = 1'b1;
    tick(2);
    cmp("s2_a", 32'(operand_a), 32'h0007);
    press(4'hF);

    // digit saturation and ignored '=' in ENTER_A
    press(4'h9); press(4'h8); press(4'h7);
    press(4'h6); press(4'h5);
    cmp("s3_a", 32'(operand_a), 32'h9876);
    press(4'hE);
    cmp("s3_disp", 32'(display_sel), 32'h0);
    cmp("s3_starts", 32'(n_start), 32'd1);

    // operator replace, '=' without B digits
    press(4'hA); press(4'hC); press(4'hE);
    cmp("s4_op", 32'(op), 32'h2);
    cmp("s4_disp", 32'(display_sel), 32'h1);
    cmp("s4_starts", 32'(n_start), 32'd1);
    done_pulse(16'h1111);

    // F ignored while waiting, then chain via B
    press(4'h1); press(4'hE);
    cmp("s5_starts", 32'(n_start), 32'd2);
    press(4'hF);
    cmp("s5_freeze_a", 32'(operand_a), 32'h9876);
    done_pulse(16'h0168);
    press(4'hB);
    cmp("s5_a", 32'(operand_a), 32'h0168);
    cmp("s5_op", 32'(op), 32'h1);
    cmp("s5_b", 32'(operand_b), 32'h0);
    cmp("s5_disp", 32'(display_sel), 32'h1);

    // digit after a result starts a fresh operand
    press(4'h2); press(4'hE);
    done_pulse(16'h0002);
    press(4'h3);
    cmp("s6_a", 32'(operand_a), 32'h0003);
    cmp("s6_disp", 32'(display_sel), 32'h0);

    // reset while waiting; late done must be ignored
    press(4'h4); press(4'hA); press(4'h5); press(4'hE);
    cmp("s7_starts", 32'(n_start), 32'd4);
    do_reset();
    done_pulse(16'h4321);
    tick(4);
    cmp("s7_a", 32'(operand_a), 32'h0);
    cmp("s7_b", 32'(operand_b), 32'h0);
    cmp("s7_op", 32'(op), 32'h0);
    cmp("s7_disp", 32'(display_sel), 32'h0);
    cmp("s7_starts", 32'(n_start), 32'd4);
    cmp("model_starts", 32'(n_start), 32'(m_starts));
    press(4'h6);
    cmp("s7_post_a", 32'(operand_a), 32'h0006);

    chk_en = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
